fifo_tx_unpack: RTL and testbench

//   TX data path for QSPI writes/programs: CSR/DMA pushes WIDTH-bit words into a DEPTH-entry FIFO;
//   an unpacker pops words and presents them to the QSPI FSM one byte at a time on a valid/ready stream.

---
 rtl/fifo_tx_unpack.sv | 117 +++++++++++
 tb/tb_fifo_tx_unpack.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_unpack.sv
// TX word FIFO feeding a byte unpacker toward the QSPI FSM.
// Define FIFO_TX_BSWAP_EN for MSB-first byte order.
module fifo_tx_unpack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [7:0]       level_o,
  output logic             byte_valid_o,
  output logic [7:0]       byte_o,
  input  logic             byte_ready_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             overflow_o,
  input  logic             clr_err_i
);

  localparam int BYTES = WIDTH / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [7:0]       level;
  logic [0:0]       state;
  logic [WIDTH-1:0] hold;
  logic [IW-1:0]    idx;
  logic [7:0]       byte_sel;

  logic push;
  logic pop;
  logic hs;
  logic last;

  assign full_o  = (level == 8'(DEPTH));
  assign empty_o = (level == 8'd0);
  assign level_o = level;

  assign byte_valid_o = (state == S_HOLD);
  assign busy_o       = !empty_o | byte_valid_o;

  assign push = wr_en_i & !full_o;
  assign hs   = byte_valid_o & byte_ready_i;
  assign last = hs & (idx == LAST);
  assign pop  = !empty_o & ((state == S_EMPTY) | last);

  always_ff @(posedge clk) begin
    if (push && !flush_i) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 8'd1;
      else if (pop && !push) level <= level - 8'd1;
    end
  end

  // Clear beats a same-cycle overflowing push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              overflow_o <= 1'b0;
    else if (clr_err_i)     overflow_o <= 1'b0;
    else if (wr_en_i && full_o) overflow_o <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_EMPTY;
      hold  <= '0;
      idx   <= '0;
    end else if (flush_i) begin
      state <= S_EMPTY;
      hold  <= '0;
      idx   <= '0;
    end else if (pop) begin
      state <= S_HOLD;
      hold  <= mem[rd_ptr];
      idx   <= '0;
    end else if (last) begin
      state <= S_EMPTY;
      idx   <= '0;
    end else if (hs) begin
      idx <= idx + 1'b1;
    end
  end

  always_comb begin
    byte_sel = 8'h00;
`ifdef FIFO_TX_BSWAP_EN
    byte_sel = hold[WIDTH-1-8*int'(idx) -: 8];
`else
    byte_sel = hold[8*int'(idx) +: 8];
`endif
  end

  assign byte_o = byte_valid_o ? byte_sel : 8'h00;

endmodule

// File: tb/tb_fifo_tx_unpack.sv
// Directed bench for fifo_tx_unpack (WIDTH=32, DEPTH=4).
// Honors FIFO_TX_BSWAP_EN for expected byte order.
module tb_fifo_tx_unpack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic        full;
  logic        empty;
  logic [7:0]  level;
  logic        byte_valid;
  logic [7:0]  byte_out;
  logic        byte_ready = 1'b0;
  logic        flush = 1'b0;
  logic        busy;
  logic        overflow;
  logic        clr_err = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  fifo_tx_unpack #(.WIDTH(32), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
    .byte_valid_o (byte_valid),
    .byte_o       (byte_out),
    .byte_ready_i (byte_ready),
    .flush_i      (flush),
    .busy_o       (busy),
    .overflow_o   (overflow),
    .clr_err_i    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input bit keep);
    wr_en = 1'b1;
    wr_data = w;
    tick();
    wr_en = 1'b0;
    if (keep) exp_q.push_back(w);
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
    logic [31:0] t;
`ifdef FIFO_TX_BSWAP_EN
    t = w >> (8 * (3 - k));
`else
    t = w >> (8 * k);
`endif
    return t[7:0];
  endfunction

  task automatic drain();
    int n;
    n = exp_q.size() * 4;
    byte_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check("drain_valid", 32'(byte_valid), 32'd1);
      check("drain_byte", 32'(byte_out), 32'(exp_byte(exp_q[k/4], k%4)));
      tick();
    end
    byte_ready = 1'b0;
    exp_q.delete();
    check("drain_done_valid", 32'(byte_valid), 32'd0);
    check("drain_done_empty", 32'(empty), 32'd1);
    check("drain_done_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_byte"}, 32'(byte_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #12;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;
    tick();

    push(32'h11223344, 1'b1);
    check("lat_e0_valid", 32'(byte_valid), 32'd0);
    check("lat_e0_level", 32'(level), 32'd1);
    push(32'h55667788, 1'b1);
    check("lat_e1_valid", 32'(byte_valid), 32'd1);
    check("lat_e1_byte", 32'(byte_out), 32'(exp_byte(32'h11223344, 0)));
    check("lat_e1_level", 32'(level), 32'd1);
    push(32'h99AABBCC, 1'b1);
    push(32'hDDEEFF00, 1'b1);
    check("fill3_level", 32'(level), 32'd3);
    check("fill3_full", 32'(full), 32'd0);
    push(32'h01020304, 1'b1);
    check("fill4_level", 32'(level), 32'd4);
    check("fill4_full", 32'(full), 32'd1);
    tick();
    check("stall_byte", 32'(byte_out), 32'(exp_byte(32'h11223344, 0)));
    drain();

    for (int i = 0; i < 5; i++) push(32'h10203040 + 32'(i), 1'b1);
    check("ovf_pre_full", 32'(full), 32'd1);
    check("ovf_pre_flag", 32'(overflow), 32'd0);
    push(32'hDEADBEEF, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd4);
    tick();
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_err = 1'b1;
    tick();
    check("ovf_clr", 32'(overflow), 32'd0);
    wr_en = 1'b1;
    wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    clr_err = 1'b0;
    check("ovf_clr_wins", 32'(overflow), 32'd0);
    check("ovf_clr_level", 32'(level), 32'd4);
    drain();

    push(32'h0A0B0C0D, 1'b0);
    push(32'h01020304, 1'b0);
    byte_ready = 1'b1;
    tick();
    tick();
    byte_ready = 1'b0;
    check("pre_flush_byte", 32'(byte_out), 32'(exp_byte(32'h0A0B0C0D, 2)));
    check("pre_flush_level", 32'(level), 32'd1);
    flush = 1'b1;
    wr_en = 1'b1;
    wr_data = 32'h77777777;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(byte_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    push(32'hCAFEF00D, 1'b1);
    tick();
    check("post_flush_byte", 32'(byte_out), 32'(exp_byte(32'hCAFEF00D, 0)));
    drain();

    for (int i = 0; i < 5; i++) push(32'hA0B0C0D0 + 32'(i), 1'b1);
    push(32'hDEADBEEF, 1'b0);
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
    check("mid_valid", 32'(byte_valid), 32'd1);
    check("mid_ovf", 32'(overflow), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_reset_state("post_rst");
    push(32'h11223344, 1'b1);
    tick();
    check("post_rst_byte", 32'(byte_out), 32'(exp_byte(32'h11223344, 0)));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
